budget_regulator: RTL and testbench

Parametrised per-queue memory-bandwidth regulator, the next generation of the MemGuard block. Each of NUMBER_OF_QUEUES request queues receives a transaction budget that is replenished every hyper-period. The block selects one eligible queue per cycle under a fixed-priority or round-robin policy and decrements that queue's budget only when downstream accepts. Optional slack reclamation serves exhausted queues best-effort when no queue holds budget. It sits between the per-core request queues and the memory-side scheduler.

---
 rtl/budget_regulator_pkg.sv | 11 +
 rtl/rotating_priority_picker.sv | 31 +++
 rtl/budget_regulator.sv | 132 +++++++++++++
 tb/tb_budget_regulator.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/budget_regulator_pkg.sv
// Shared constants and helpers for the per-queue bandwidth regulator.
package budget_regulator_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rotating_priority_picker.sv
// Finds the first set request, scanning from i_start (round-robin)
// or from index 0 (fixed priority).
module rotating_priority_picker
    import budget_regulator_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    input  logic         i_mode,
    output logic         o_found,
    output logic [W-1:0] o_index
);

    always_comb begin
        int j;
        j       = 0;
        o_found = 1'b0;
        o_index = '0;
        for (int k = 0; k < N; k++) begin
            j = (i_mode == MODE_RR) ? int'(i_start) + k : k;
            if (j >= N) j = j - N;
            if (!o_found && i_req[j]) begin
                o_found = 1'b1;
                o_index = W'(j);
            end
        end
    end

endmodule

// File: rtl/budget_regulator.sv
// Per-queue transaction budgets replenished every hyper-period, with
// fixed-priority or round-robin selection and optional slack reclamation.
module budget_regulator
    import budget_regulator_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32,
    parameter int SELECTION_WIDTH  = sel_width(NUMBER_OF_QUEUES)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] budgets,
    input  logic [REGISTER_SIZE-1:0]                      hyper_period,
    input  logic                                          mode,
    input  logic                                          reclaim_enable,
    input  logic [NUMBER_OF_QUEUES-1:0]                   empty,
    input  logic                                          accept,
    output logic                                          valid,
    output logic [SELECTION_WIDTH-1:0]                    selection,
    output logic                                          reclaimed,
    output logic                                          period_start,
    output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] remaining
);

    localparam logic [SELECTION_WIDTH-1:0] LAST_Q =
        SELECTION_WIDTH'(NUMBER_OF_QUEUES - 1);

    logic [REGISTER_SIZE-1:0]                      r_count;
    logic [REGISTER_SIZE-1:0]                      r_hp;
    logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] r_remaining;
    logic [SELECTION_WIDTH-1:0]                    r_rr_ptr;
    logic                                          r_period_start;

    logic [REGISTER_SIZE-1:0]    w_hp_eff;
    logic                        w_wrap;
    logic [NUMBER_OF_QUEUES-1:0] w_elig;
    logic [NUMBER_OF_QUEUES-1:0] w_nonempty;
    logic [SELECTION_WIDTH-1:0]  w_rr_start;
    logic                        w_elig_found;
    logic [SELECTION_WIDTH-1:0]  w_elig_idx;
    logic                        w_ne_found;
    logic [SELECTION_WIDTH-1:0]  w_ne_idx;
    logic                        w_use_reclaim;
    logic                        w_charge;

    // A latched hyper-period of zero behaves as a one-cycle period.
    assign w_hp_eff = (r_hp == '0) ? REGISTER_SIZE'(1) : r_hp;
    assign w_wrap   = (r_count >= w_hp_eff - REGISTER_SIZE'(1));

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            w_elig[i] = !empty[i] && (r_remaining[i] != '0);
        end
    end

    assign w_nonempty = ~empty;
    assign w_rr_start = (r_rr_ptr == LAST_Q) ? '0
                      : r_rr_ptr + SELECTION_WIDTH'(1);

    rotating_priority_picker #(
        .N (NUMBER_OF_QUEUES),
        .W (SELECTION_WIDTH)
    ) u_pick_elig (
        .i_req   (w_elig),
        .i_start (w_rr_start),
        .i_mode  (mode),
        .o_found (w_elig_found),
        .o_index (w_elig_idx)
    );

    rotating_priority_picker #(
        .N (NUMBER_OF_QUEUES),
        .W (SELECTION_WIDTH)
    ) u_pick_ne (
        .i_req   (w_nonempty),
        .i_start (w_rr_start),
        .i_mode  (mode),
        .o_found (w_ne_found),
        .o_index (w_ne_idx)
    );

    assign w_use_reclaim = !w_elig_found && reclaim_enable && w_ne_found;

    always_comb begin
        valid     = 1'b0;
        selection = '0;
        reclaimed = 1'b0;
        if (!reset) begin
            if (w_elig_found) begin
                valid     = 1'b1;
                selection = w_elig_idx;
            end else if (w_use_reclaim) begin
                valid     = 1'b1;
                reclaimed = 1'b1;
                selection = w_ne_idx;
            end
        end
    end

    assign w_charge     = accept && valid && !reclaimed;
    assign period_start = r_period_start && !reset;
    assign remaining    = r_remaining;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count        <= '0;
            r_hp           <= hyper_period;
            r_remaining    <= budgets;
            r_rr_ptr       <= LAST_Q;
            r_period_start <= 1'b1;
        end else begin
            r_period_start <= w_wrap;
            // Reload overrides a same-cycle charge.
            if (w_wrap) begin
                r_count     <= '0;
                r_hp        <= hyper_period;
                r_remaining <= budgets;
            end else begin
                r_count <= r_count + REGISTER_SIZE'(1);
                if (w_charge) begin
                    r_remaining[selection] <=
                        r_remaining[selection] - REGISTER_SIZE'(1);
                end
            end
            if (w_charge) begin
                r_rr_ptr <= selection;
            end
        end
    end

endmodule

// File: tb/tb_budget_regulator.sv
// Directed-vector bench for budget_regulator.
module tb_budget_regulator;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0][31:0] budgets;
    logic [31:0]      hyper_period;
    logic             mode;
    logic             reclaim_enable;
    logic [3:0]       empty;
    logic             accept;
    logic             valid;
    logic [1:0]       selection;
    logic             reclaimed;
    logic             period_start;
    logic [3:0][31:0] remaining;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    budget_regulator dut (
        .clock          (clk),
        .reset          (reset),
        .budgets        (budgets),
        .hyper_period   (hyper_period),
        .mode           (mode),
        .reclaim_enable (reclaim_enable),
        .empty          (empty),
        .accept         (accept),
        .valid          (valid),
        .selection      (selection),
        .reclaimed      (reclaimed),
        .period_start   (period_start),
        .remaining      (remaining)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_rem(input string tag, input int e0, input int e1,
                             input int e2, input int e3);
        check({tag, ".rem0"}, remaining[0], e0);
        check({tag, ".rem1"}, remaining[1], e1);
        check({tag, ".rem2"}, remaining[2], e2);
        check({tag, ".rem3"}, remaining[3], e3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the check window of cycle 0.
    task automatic start_run();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        tick();
        #1;
    endtask

    task automatic set_default_budgets();
        budgets[0] = 32'd1;
        budgets[1] = 32'd2;
        budgets[2] = 32'd3;
        budgets[3] = 32'd4;
    endtask

    int fp_seq [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    int rr_seq [10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};

    initial begin
        reset          = 1'b1;
        set_default_budgets();
        hyper_period   = 32'd12;
        mode           = 1'b0;
        reclaim_enable = 1'b0;
        empty          = 4'b0000;
        accept         = 1'b1;

        // Outputs held quiet during reset
        tick();
        tick();
        #1;
        check("rst.valid", 32'(valid), 0);
        check("rst.sel", 32'(selection), 0);
        check("rst.recl", 32'(reclaimed), 0);
        check("rst.pstart", 32'(period_start), 0);
        check_rem("rst", 1, 2, 3, 4);

        // Fixed priority
        start_run();
        for (int c = 0; c < 13; c++) begin
            if (c > 0) next_cycle();
            if (c < 10) begin
                check($sformatf("fp.valid%0d", c), 32'(valid), 1);
                check($sformatf("fp.sel%0d", c), 32'(selection), fp_seq[c]);
            end else if (c < 12) begin
                check($sformatf("fp.valid%0d", c), 32'(valid), 0);
            end
            check($sformatf("fp.pstart%0d", c), 32'(period_start),
                  (c == 0 || c == 12) ? 1 : 0);
        end
        check("fp.sel12", 32'(selection), 0);
        check_rem("fp.c12", 1, 2, 3, 4);

        // Round-robin
        mode = 1'b1;
        start_run();
        for (int c = 0; c < 13; c++) begin
            if (c > 0) next_cycle();
            if (c < 10) begin
                check($sformatf("rr.sel%0d", c), 32'(selection), rr_seq[c]);
                check($sformatf("rr.valid%0d", c), 32'(valid), 1);
            end else if (c < 12) begin
                check($sformatf("rr.valid%0d", c), 32'(valid), 0);
            end
        end
        check("rr.sel12", 32'(selection), 0);
        check("rr.pstart12", 32'(period_start), 1);

        // Slack reclamation
        mode           = 1'b0;
        reclaim_enable = 1'b1;
        start_run();
        for (int c = 0; c < 12; c++) begin
            if (c > 0) next_cycle();
            if (c == 9) check("rc.recl9", 32'(reclaimed), 0);
            if (c >= 10) begin
                check($sformatf("rc.valid%0d", c), 32'(valid), 1);
                check($sformatf("rc.recl%0d", c), 32'(reclaimed), 1);
                check($sformatf("rc.sel%0d", c), 32'(selection), 0);
                check_rem($sformatf("rc%0d", c), 0, 0, 0, 0);
            end
        end
        reclaim_enable = 1'b0;

        // Mid-period config change and accept stall
        start_run();
        for (int c = 1; c < 13; c++) begin
            tick();
            if (c == 3) budgets[0] = 32'd5;
            accept = (c == 4 || c == 5) ? 1'b0 : 1'b1;
            #1;
            if (c == 3) check_rem("cf3", 0, 0, 3, 4);
            if (c >= 4 && c <= 6) begin
                check_rem($sformatf("cf%0d", c), 0, 0, 2, 4);
                check($sformatf("cf.sel%0d", c), 32'(selection), 2);
            end
        end
        check_rem("cf12", 5, 2, 3, 4);
        check("cf.pstart12", 32'(period_start), 1);
        set_default_budgets();
        accept = 1'b1;

        // Zero hyper-period
        hyper_period = 32'd0;
        start_run();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next_cycle();
            check($sformatf("hp0.pstart%0d", c), 32'(period_start), 1);
            check($sformatf("hp0.sel%0d", c), 32'(selection), 0);
            check($sformatf("hp0.valid%0d", c), 32'(valid), 1);
            check_rem($sformatf("hp0.%0d", c), 1, 2, 3, 4);
        end
        hyper_period = 32'd12;

        // Reset asserted mid-period
        start_run();
        for (int c = 1; c < 8; c++) begin
            tick();
            reset = (c == 5 || c == 6) ? 1'b1 : 1'b0;
            #1;
            if (c == 5 || c == 6) begin
                check($sformatf("mr.valid%0d", c), 32'(valid), 0);
                check($sformatf("mr.pstart%0d", c), 32'(period_start), 0);
            end
        end
        check("mr.pstart", 32'(period_start), 1);
        check("mr.sel", 32'(selection), 0);
        check("mr.valid", 32'(valid), 1);
        check_rem("mr", 1, 2, 3, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
